// File: rtl/mem_req_ctrl_pkg.sv
// rtl/mem_req_ctrl_pkg.sv - shared dbus types and memory-stage FSM states
package mem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    DRAIN  = 2'd3
  } mem_ctrl_state_t;

  localparam int WAIT_CNT_W = 16;

  // Byte-lane mask of an access of the given size, before shifting to its offset.
  function automatic strobe_t size_mask(input msize_t size);
    case (size)
      MSIZE1:  size_mask = 8'h01;
      MSIZE2:  size_mask = 8'h03;
      MSIZE4:  size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_ctrl_dbus_lane_gen.sv
// rtl/mem_req_ctrl_dbus_lane_gen.sv - byte-lane strobe, store data shift and alignment check
module dbus_lane_gen
  import mem_req_ctrl_pkg::*;
(
  input  msize_t      size_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output strobe_t     strobe_o,
  output logic [63:0] data_o,
  output logic        misaligned_o
);

  logic [2:0] off;
  assign off = addr_i[2:0];

  // Place the store bytes on their lanes and flag addresses not aligned to the size.
  always_comb begin
    strobe_o = size_mask(size_i) << off;
    data_o   = wdata_i << {off, 3'b000};
    case (size_i)
      MSIZE1:  misaligned_o = 1'b0;
      MSIZE2:  misaligned_o = off[0];
      MSIZE4:  misaligned_o = |off[1:0];
      default: misaligned_o = |off;
    endcase
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - memory-stage dbus sequencer: latch, hold, drain, complete
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int WAIT_LIMIT = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  msize_t          req_size,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            flush,
  input  logic            stall_in,
  input  dbus_resp_t      dresp,
  output dbus_req_t       dreq,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            misalign_ex,
  output logic            busy,
  output logic            bus_timeout
);

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WAIT_CNT_W-1:0] LIMIT   = WAIT_CNT_W'(WAIT_LIMIT);

  mem_ctrl_state_t       state_q;
  dbus_req_t             req_q;
  logic                  write_q;
  logic [XLEN-1:0]       rdata_q;
  logic                  done_q;
  logic                  timeout_q;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  strobe_t     lane_strobe;
  logic [63:0] lane_data;
  logic        lane_misaligned;

  logic in_idle;
  logic waiting;
  logic accept;
  logic timeout_hit;

  dbus_lane_gen u_lane_gen (
    .size_i       (req_size),
    .addr_i       (req_addr),
    .wdata_i      (req_wdata),
    .strobe_o     (lane_strobe),
    .data_o       (lane_data),
    .misaligned_o (lane_misaligned)
  );

  assign in_idle = (state_q == IDLE);
  assign waiting = (state_q == ACCESS) || (state_q == DRAIN);
  assign accept  = in_idle && req_valid && !flush && !lane_misaligned;

  // Misaligned accesses complete immediately in IDLE without a bus cycle.
  assign misalign_ex = in_idle && req_valid && !flush && lane_misaligned;
  assign done        = done_q || misalign_ex;
  assign busy        = accept || waiting;
  assign dreq        = req_q;
  assign rdata       = rdata_q;
  assign bus_timeout = timeout_q;

  // Saturating count of cycles spent waiting on the bus; zero outside ACCESS/DRAIN.
  always_comb begin
    cnt_d = '0;
    if (waiting) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (WAIT_LIMIT != 0) && waiting && (cnt_d >= LIMIT);

  // Request sequencer: latches the access, keeps dreq stable until data_ok, presents the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      req_q     <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q      <= ACCESS;
            write_q      <= req_write;
            req_q.valid  <= 1'b1;
            req_q.addr   <= req_addr;
            req_q.size   <= req_size;
            req_q.strobe <= req_write ? lane_strobe : '0;
            req_q.data   <= req_write ? lane_data : '0;
          end
        end
        ACCESS: begin
          if (dresp.data_ok) begin
            req_q.valid <= 1'b0;
            if (flush) begin
              state_q <= IDLE;
            end else begin
              rdata_q <= write_q ? '0 : dresp.data;
              done_q  <= 1'b1;
              state_q <= stall_in ? HOLD : IDLE;
            end
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        HOLD: begin
          if (!stall_in || flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (dresp.data_ok) begin
            req_q.valid <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  msize_t      req_size;
  logic [63:0] req_wdata;
  logic        flush;
  logic        stall_in;
  dbus_resp_t  dresp;
  dbus_req_t   dreq;
  logic [63:0] rdata;
  logic        done;
  logic        misalign_ex;
  logic        busy;
  logic        bus_timeout;

  int checks;
  int failures;

  mem_req_ctrl #(.XLEN(64), .WAIT_LIMIT(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .flush       (flush),
    .stall_in    (stall_in),
    .dresp       (dresp),
    .dreq        (dreq),
    .rdata       (rdata),
    .done        (done),
    .misalign_ex (misalign_ex),
    .busy        (busy),
    .bus_timeout (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One memory-stage instruction. lat: cycle after accept on which data_ok comes (>=1);
  // flush_at: ACCESS-phase cycle carrying a one-cycle flush (0 = none);
  // s: number of cycles stall_in is held starting at the data_ok cycle.
  task automatic do_access(input logic wr, input logic [63:0] addr, input int sz,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int lat, input int flush_at, input int s);
    int          nb;
    int          off;
    logic        mis;
    logic [63:0] e_strb;
    logic [63:0] e_data;
    int          n_done;
    nb     = 1 << sz;
    off    = int'(addr % 8);
    mis    = (addr % nb) != 0;
    e_strb = wr ? ((((64'd1 << nb) - 1) << off) & 64'hff) : 64'd0;
    e_data = wd << (8 * off);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = msize_t'(sz);
    req_wdata = wd;
    flush     = 1'b0;
    stall_in  = 1'b0;
    #1;
    if (mis) begin
      chk("mis_done", done, 1);
      chk("mis_ex", misalign_ex, 1);
      chk("mis_busy", busy, 0);
      chk("mis_valid", dreq.valid, 0);
      step();
      req_valid = 1'b0;
      #1;
      chk("mis_done_after", done, 0);
      chk("mis_valid_after", dreq.valid, 0);
      step();
      return;
    end
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    step();
    for (int i = 1; i <= lat; i++) begin
      req_valid     = 1'b0;
      req_addr      = {$urandom, $urandom};
      dresp.data_ok = (i == lat);
      dresp.data    = (i == lat) ? rd : {$urandom, $urandom};
      flush         = (i == flush_at);
      stall_in      = (i == lat) && (s > 0);
      #1;
      chk("wait_valid", dreq.valid, 1);
      chk("wait_addr", dreq.addr, addr);
      chk("wait_size", 64'(dreq.size), 64'(sz));
      chk("wait_strobe", 64'(dreq.strobe), e_strb);
      if (wr) chk("wait_data", dreq.data, e_data);
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
      chk("wait_timeout", bus_timeout, 0);
      step();
    end
    dresp.data_ok = 1'b0;
    flush         = 1'b0;
    if (flush_at == 0) begin
      n_done = (s > 1) ? s : 1;
      for (int k = 1; k <= n_done; k++) begin
        stall_in = (k < s);
        #1;
        chk("res_done", done, 1);
        chk("res_rdata", rdata, wr ? 64'd0 : rd);
        chk("res_busy", busy, 0);
        chk("res_valid", dreq.valid, 0);
        step();
      end
    end
    stall_in = 1'b0;
    #1;
    chk("end_done", done, 0);
    chk("end_valid", dreq.valid, 0);
    chk("end_busy", busy, 0);
    step();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    resetn        = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_size      = MSIZE1;
    req_wdata     = '0;
    flush         = 1'b0;
    stall_in      = 1'b0;
    dresp         = '0;

    step();
    step();
    chk("rst_dreq", 64'(dreq != '0), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_mis", misalign_ex, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", bus_timeout, 0);
    resetn = 1'b1;
    step();

    do_access(1'b0, 64'h8000_0008, 3, 64'd0, 64'hDEADBEEF_01234567, 3, 0, 0);
    do_access(1'b1, 64'h8000_0006, 1, 64'hABCD, 64'h1111, 2, 0, 0);
    do_access(1'b0, 64'h8000_0002, 2, 64'd0, 64'd0, 1, 0, 0);
    do_access(1'b0, 64'h8000_0010, 3, 64'd0, 64'h5555, 3, 1, 0);
    do_access(1'b0, 64'h8000_0020, 2, 64'd0, 64'hCAFE_F00D, 2, 0, 4);
    do_access(1'b0, 64'h8000_0030, 3, 64'd0, 64'h7777, 2, 2, 0);
    do_access(1'b0, 64'h8000_0000, 3, 64'd0, 64'h1234, 1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int          sz;
      int          lat;
      int          fa;
      logic [63:0] a;
      sz  = int'($urandom_range(0, 3));
      a   = {32'h8000_0000, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      lat = int'($urandom_range(1, 5));
      fa  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : 0;
      do_access(1'($urandom), a, sz, {$urandom, $urandom}, {$urandom, $urandom},
                lat, fa, int'($urandom_range(0, 3)));
    end

    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h8000_0040;
    req_size  = MSIZE8;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("to_valid", dreq.valid, 1);
      chk("to_flag", bus_timeout, 64'((k - 1) >= 8));
      step();
    end
    resetn = 1'b0;
    #1;
    chk("to_rst_valid", dreq.valid, 0);
    chk("to_rst_flag", bus_timeout, 0);
    chk("to_rst_busy", busy, 0);
    #2;
    resetn = 1'b1;
    step();
    do_access(1'b1, 64'h8000_0004, 2, 64'h0BAD_F00D, 64'd0, 2, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
